wb_fabric_frame_gen_chk: RTL and testbench

- Self-contained Wishbone-fabric traffic block for the FEC datapath.
- The source port emits Ethernet frames on a pipelined 16-bit fabric (adr 2 b, dat 16 b, sel 2 b): fixed header, LFSR-generated payload, programmable inter-frame gap.
- The sink port accepts frames from the device under test, with optional pseudo-random stalls, and reports each frame's dst/src/size.
- Sits between the FEC encoder/decoder fabric ports and the system bus; provides synthesizable traffic generation and checking.

---
 rtl/wb_fabric_frame_gen_chk.sv | 249 ++++++++++++++++++++++++
 tb/tb_wb_fabric_frame_gen_chk.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fabric_frame_gen_chk.sv
// Wishbone-fabric frame generator (source) and frame checker (sink) for the FEC datapath.
// The source emits status + header + LFSR payload frames; the sink acks, stalls and reports frames.
module wb_fabric_frame_gen_chk #(
  parameter int          g_payload_len   = 500,
  parameter int          g_gap_cycles    = 12500,
  parameter logic [31:0] g_seed          = 32'd100,
  parameter int          g_random_stalls = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [47:0] dst_mac_i,
  input  logic [47:0] src_mac_i,
  output logic        src_cyc_o,
  output logic        src_stb_o,
  output logic        src_we_o,
  output logic [1:0]  src_adr_o,
  output logic [15:0] src_dat_o,
  output logic [1:0]  src_sel_o,
  input  logic        src_stall_i,
  input  logic        src_ack_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic        snk_we_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [15:0] snk_dat_i,
  input  logic [1:0]  snk_sel_i,
  output logic        snk_stall_o,
  output logic        snk_ack_o,
  output logic        rx_valid_o,
  output logic [47:0] rx_dst_o,
  output logic [47:0] rx_src_o,
  output logic [15:0] rx_size_o,
  output logic [31:0] tx_cnt_o,
  output logic [31:0] rx_cnt_o
);

  localparam int          lp_n_data    = 7 + (g_payload_len + 1) / 2;
  localparam logic [15:0] lp_n_data16  = 16'(lp_n_data);
  localparam logic [15:0] lp_last_idx  = 16'(lp_n_data - 1);
  localparam logic        lp_odd       = 1'(g_payload_len % 2);
  localparam logic        lp_stall_en  = (g_random_stalls != 0);
  localparam logic [31:0] lp_taps      = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_STATUS, S_DATA, S_DRAIN, S_GAP} src_state_t;

  function automatic logic [31:0] f_lfsr_step(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ lp_taps) : (v >> 1);
  endfunction

  // ---------------- source ----------------
  src_state_t  r_state;
  logic        r_cyc, r_stb;
  logic [1:0]  r_adr, r_sel;
  logic [15:0] r_dat;
  logic [31:0] r_lfsr;
  logic [15:0] r_idx;      // index of the next data word to present
  logic [15:0] r_issued;
  logic [15:0] r_acks;
  logic [31:0] r_gap_cnt;
  logic [31:0] r_tx_cnt;

  logic [31:0] w_b1, w_b2, w_lfsr_nxt;
  logic [15:0] w_word_dat;
  logic [1:0]  w_word_sel;
  logic        w_src_take;

  assign w_b1       = f_lfsr_step(r_lfsr);
  assign w_b2       = f_lfsr_step(w_b1);
  assign w_src_take = r_stb && !src_stall_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_word_dat = '0;
    w_word_sel = 2'b11;
    w_lfsr_nxt = r_lfsr;
    case (r_idx)
      16'd0:   w_word_dat = dst_mac_i[47:32];
      16'd1:   w_word_dat = dst_mac_i[31:16];
      16'd2:   w_word_dat = dst_mac_i[15:0];
      16'd3:   w_word_dat = src_mac_i[47:32];
      16'd4:   w_word_dat = src_mac_i[31:16];
      16'd5:   w_word_dat = src_mac_i[15:0];
      16'd6:   w_word_dat = 16'(g_payload_len);
      default: begin
        if (lp_odd && r_idx == lp_last_idx) begin
          w_word_dat = {w_b1[7:0], 8'h00};
          w_word_sel = 2'b10;
          w_lfsr_nxt = w_b1;
        end else begin
          w_word_dat = {w_b1[7:0], w_b2[7:0]};
          w_lfsr_nxt = w_b2;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= 2'b11;
      r_lfsr    <= g_seed;
      r_idx     <= '0;
      r_issued  <= '0;
      r_acks    <= '0;
      r_gap_cnt <= '0;
      r_tx_cnt  <= '0;
    end else begin
      if (r_cyc && src_ack_i) r_acks <= r_acks + 16'd1;
      case (r_state)
        S_IDLE: if (en_i) begin
          r_cyc    <= 1'b1;
          r_stb    <= 1'b1;
          r_adr    <= 2'd2;
          r_dat    <= '0;
          r_sel    <= 2'b11;
          r_lfsr   <= g_seed;
          r_idx    <= '0;
          r_issued <= '0;
          r_acks   <= '0;
          r_state  <= S_STATUS;
        end
        S_STATUS, S_DATA: if (w_src_take) begin
          r_issued <= r_issued + 16'd1;
          if (r_idx == lp_n_data16) begin
            r_stb   <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= 2'b11;
            r_state <= S_DRAIN;
          end else begin
            r_adr   <= 2'd0;
            r_dat   <= w_word_dat;
            r_sel   <= w_word_sel;
            r_lfsr  <= w_lfsr_nxt;
            r_idx   <= r_idx + 16'd1;
            r_state <= S_DATA;
          end
        end
        S_DRAIN: if (r_acks == r_issued) begin
          r_cyc     <= 1'b0;
          r_tx_cnt  <= r_tx_cnt + 32'd1;
          r_gap_cnt <= '0;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt + 32'd1 >= 32'(g_gap_cycles)) r_state <= S_IDLE;
          else r_gap_cnt <= r_gap_cnt + 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign src_cyc_o = r_cyc;
  assign src_stb_o = r_stb;
  assign src_we_o  = 1'b1;
  assign src_adr_o = r_adr;
  assign src_dat_o = r_dat;
  assign src_sel_o = r_sel;
  assign tx_cnt_o  = r_tx_cnt;

  // ---------------- sink ----------------
  logic [15:0] r_stall_lfsr;
  logic        r_snk_ack, r_cyc_d, r_any;
  logic [2:0]  r_words;
  logic [47:0] r_dst_acc, r_src_acc;
  logic [15:0] r_size_acc;
  logic        r_rx_valid;
  logic [47:0] r_rx_dst, r_rx_src;
  logic [15:0] r_rx_size;
  logic [31:0] r_rx_cnt;

  logic        w_snk_stall, w_snk_take;
  logic [15:0] w_bytes;

  assign w_snk_stall = lp_stall_en & r_stall_lfsr[0] & snk_cyc_i;
  assign w_snk_take  = snk_cyc_i && snk_stb_i && !w_snk_stall;
  assign w_bytes     = {14'd0, snk_sel_i[1] & snk_sel_i[0], snk_sel_i[1] ^ snk_sel_i[0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_lfsr <= 16'hACE1;
      r_snk_ack    <= 1'b0;
      r_cyc_d      <= 1'b0;
      r_any        <= 1'b0;
      r_words      <= '0;
      r_dst_acc    <= '0;
      r_src_acc    <= '0;
      r_size_acc   <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_dst     <= '0;
      r_rx_src     <= '0;
      r_rx_size    <= '0;
      r_rx_cnt     <= '0;
    end else begin
      r_stall_lfsr <= r_stall_lfsr[0] ? ((r_stall_lfsr >> 1) ^ 16'hB400) : (r_stall_lfsr >> 1);
      r_snk_ack    <= w_snk_take;
      r_cyc_d      <= snk_cyc_i;
      r_rx_valid   <= 1'b0;
      if (w_snk_take) begin
        r_any <= 1'b1;
        // Every accepted word is acked, but only write cycles carry frame content.
        if (snk_we_i && snk_adr_i != 2'd2) begin
          case (r_words)
            3'd0: r_dst_acc[47:32] <= snk_dat_i;
            3'd1: r_dst_acc[31:16] <= snk_dat_i;
            3'd2: r_dst_acc[15:0]  <= snk_dat_i;
            3'd3: r_src_acc[47:32] <= snk_dat_i;
            3'd4: r_src_acc[31:16] <= snk_dat_i;
            3'd5: r_src_acc[15:0]  <= snk_dat_i;
            default: ;
          endcase
          if (r_words != 3'd6) r_words <= r_words + 3'd1;
          r_size_acc <= r_size_acc + w_bytes;
        end
      end
      // No word can be accepted while cyc is low, so clearing here never races a capture.
      if (r_cyc_d && !snk_cyc_i) begin
        if (r_any) begin
          r_rx_valid <= 1'b1;
          r_rx_dst   <= r_dst_acc;
          r_rx_src   <= r_src_acc;
          r_rx_size  <= r_size_acc;
          r_rx_cnt   <= r_rx_cnt + 32'd1;
        end
        r_any      <= 1'b0;
        r_words    <= '0;
        r_dst_acc  <= '0;
        r_src_acc  <= '0;
        r_size_acc <= '0;
      end
    end
  end

  assign snk_stall_o = w_snk_stall;
  assign snk_ack_o   = r_snk_ack;
  assign rx_valid_o  = r_rx_valid;
  assign rx_dst_o    = r_rx_dst;
  assign rx_src_o    = r_rx_src;
  assign rx_size_o   = r_rx_size;
  assign rx_cnt_o    = r_rx_cnt;

endmodule

// File: tb/tb_wb_fabric_frame_gen_chk.sv
// Loopback bench: three generator/checker instances (default, odd payload, no stalls) against a frame model.
module tb_wb_fabric_frame_gen_chk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [47:0] c_dst = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] c_src = 48'h0102_0304_0506;
  localparam int c_len [3] = '{500, 45, 500};
  localparam int c_gap [3] = '{12500, 20, 20};
  localparam int c_rs  [3] = '{1, 1, 0};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference payload: byte p is the seed-100 Galois LFSR value after p+1 shifts.
  function automatic logic [7:0] pay_byte(input int p);
    logic [31:0] l;
    l = 32'd100;
    for (int i = 0; i <= p; i++) l = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
    return l[7:0];
  endfunction

  // Expected source word k as {adr, sel, dat}.
  function automatic logic [19:0] exp_word(input int len, input int k);
    logic [47:0] t;
    int p;
    logic [7:0] hi, lo;
    if (k == 0) return {2'd2, 2'b11, 16'h0000};
    if (k <= 3) begin t = c_dst >> (16 * (3 - k)); return {2'd0, 2'b11, t[15:0]}; end
    if (k <= 6) begin t = c_src >> (16 * (6 - k)); return {2'd0, 2'b11, t[15:0]}; end
    if (k == 7) return {2'd0, 2'b11, 16'(len)};
    p  = 2 * (k - 8);
    hi = pay_byte(p);
    if (p + 1 < len) begin
      lo = pay_byte(p + 1);
      return {2'd0, 2'b11, hi, lo};
    end
    return {2'd0, 2'b10, hi, 8'h00};
  endfunction

  logic        rst [3], en [3], frc [3];
  logic        s_cyc [3], s_stb [3], s_we [3];
  logic [1:0]  s_adr [3], s_sel [3];
  logic [15:0] s_dat [3];
  logic        k_stall [3], k_ack [3], rx_v [3];
  logic [47:0] rx_d [3], rx_s [3];
  logic [15:0] rx_sz [3];
  logic [31:0] txc [3], rxc [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    wb_fabric_frame_gen_chk #(
      .g_payload_len(c_len[gi]), .g_gap_cycles(c_gap[gi]),
      .g_seed(32'd100), .g_random_stalls(c_rs[gi])
    ) u_dut (
      .clk_i(clk), .rst_i(rst[gi]), .en_i(en[gi]),
      .dst_mac_i(c_dst), .src_mac_i(c_src),
      .src_cyc_o(s_cyc[gi]), .src_stb_o(s_stb[gi]), .src_we_o(s_we[gi]),
      .src_adr_o(s_adr[gi]), .src_dat_o(s_dat[gi]), .src_sel_o(s_sel[gi]),
      .src_stall_i(k_stall[gi] | frc[gi]), .src_ack_i(k_ack[gi]),
      .snk_cyc_i(s_cyc[gi]), .snk_stb_i(s_stb[gi] & ~frc[gi]), .snk_we_i(s_we[gi]),
      .snk_adr_i(s_adr[gi]), .snk_dat_i(s_dat[gi]), .snk_sel_i(s_sel[gi]),
      .snk_stall_o(k_stall[gi]), .snk_ack_o(k_ack[gi]),
      .rx_valid_o(rx_v[gi]), .rx_dst_o(rx_d[gi]), .rx_src_o(rx_s[gi]), .rx_size_o(rx_sz[gi]),
      .tx_cnt_o(txc[gi]), .rx_cnt_o(rxc[gi])
    );
  end

  // Monitor state
  int          pulses [3], acks [3], issued [3], stall_hi [3], stb_cyc [3], stb_runs [3];
  logic        prev_cyc [3], prev_stb [3], rec [3];
  logic [47:0] lat_d [3], lat_s [3];
  logic [15:0] lat_sz [3];
  logic [19:0] words [3][$];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        acks[i] = 0; issued[i] = 0; prev_cyc[i] = 1'b0; prev_stb[i] = 1'b0;
      end else begin
        if (s_cyc[i] && k_ack[i]) acks[i]++;
        if (s_cyc[i] && s_stb[i] && !(k_stall[i] | frc[i])) begin
          issued[i]++;
          if (rec[i]) words[i].push_back({s_adr[i], s_sel[i], s_dat[i]});
        end
        if (rec[i]) begin
          if (k_stall[i]) stall_hi[i]++;
          if (s_stb[i]) stb_cyc[i]++;
          if (s_stb[i] && !prev_stb[i]) stb_runs[i]++;
        end
        prev_stb[i] = s_stb[i];
        if (prev_cyc[i] && !s_cyc[i]) begin
          check($sformatf("ack_vs_issued_%0d", i), acks[i], issued[i]);
          acks[i] = 0; issued[i] = 0;
        end
        prev_cyc[i] = s_cyc[i];
      end
      if (rx_v[i]) begin
        pulses[i]++;
        lat_d[i] = rx_d[i]; lat_s[i] = rx_s[i]; lat_sz[i] = rx_sz[i];
      end
    end
  end

  task automatic check_frame(input int i, input string nm);
    int len, nw;
    len = c_len[i];
    nw  = 8 + (len + 1) / 2;
    check({nm, "_nwords"}, words[i].size(), nw);
    for (int k = 0; k < nw && k < words[i].size(); k++)
      check($sformatf("%s_word%0d", nm, k), words[i][k], exp_word(len, k));
    check({nm, "_rx_dst"}, lat_d[i], c_dst);
    check({nm, "_rx_src"}, lat_s[i], c_src);
    check({nm, "_rx_size"}, lat_sz[i], 14 + len);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; frc[i] = 1'b0; rec[i] = 1'b1;
      pulses[i] = 0; stall_hi[i] = 0; stb_cyc[i] = 0; stb_runs[i] = 0;
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", s_cyc[0], 0);
    check("rst_stb", s_stb[0], 0);
    check("rst_we", s_we[0], 1);
    check("rst_sel", s_sel[0], 2'b11);
    check("rst_adr", s_adr[0], 0);
    check("rst_dat", s_dat[0], 0);
    check("rst_snk_stall", k_stall[0], 0);
    check("rst_snk_ack", k_ack[0], 0);
    check("rst_rx_valid", rx_v[0], 0);
    check("rst_rx_dst", rx_d[0], 0);
    check("rst_rx_size", rx_sz[0], 0);
    check("rst_tx_cnt", txc[0], 0);
    check("rst_rx_cnt", rxc[0], 0);
    @(posedge clk) #1;
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b0; en[i] = 1'b1; end

    fork
      begin : scen_a
        int n, p0;
        logic        snap_stb;
        logic [15:0] snap_dat;
        logic [1:0]  snap_adr;
        n = 0;
        while (words[0].size() < 100 && n < 3000) begin @(negedge clk); n++; end
        check("a_reach_mid", words[0].size() >= 100, 1);
        // Hold the source stalled for 20 cycles in mid-frame.
        @(posedge clk) #1 frc[0] = 1'b1;
        @(negedge clk);
        snap_stb = s_stb[0]; snap_dat = s_dat[0]; snap_adr = s_adr[0];
        check("a_stall_stb", snap_stb, 1);
        for (int j = 1; j < 20; j++) begin
          @(negedge clk);
          check("a_stall_stb", s_stb[0], 1);
          check("a_stall_dat", s_dat[0], snap_dat);
          check("a_stall_adr", s_adr[0], snap_adr);
        end
        @(posedge clk) #1 frc[0] = 1'b0;
        n = 0;
        while (pulses[0] < 1 && n < 5000) begin @(negedge clk); n++; end
        check("a_f1_done", pulses[0], 1);
        check_frame(0, "a_f1");
        check("a_f1_first_payload", words[0].size() > 8 ? words[0][8][15:8] : 8'hxx, pay_byte(0));
        check("a_f1_tx_cnt", txc[0], 1);
        check("a_f1_rx_cnt", rxc[0], 1);
        words[0].delete();
        n = 0;
        while (pulses[0] < 2 && n < 16000) begin @(negedge clk); n++; end
        check("a_f2_done", pulses[0], 2);
        check_frame(0, "a_f2");
        check("a_f2_tx_cnt", txc[0], 2);
        check("a_f2_rx_cnt", rxc[0], 2);
        // Reset in the middle of the third frame.
        n = 0;
        while (!s_cyc[0] && n < 16000) begin @(negedge clk); n++; end
        check("a_f3_start", s_cyc[0], 1);
        repeat (50) @(negedge clk);
        p0 = pulses[0];
        @(posedge clk) #1 rst[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_rst_cyc", s_cyc[0], 0);
        check("a_rst_stb", s_stb[0], 0);
        check("a_rst_tx_cnt", txc[0], 0);
        check("a_rst_rx_cnt", rxc[0], 0);
        @(posedge clk) #1 rst[0] = 1'b0;
        words[0].delete();
        repeat (5) @(negedge clk);
        check("a_no_partial_pulse", pulses[0], p0);
        n = 0;
        while (pulses[0] < p0 + 1 && n < 5000) begin @(negedge clk); n++; end
        check("a_post_rst_done", pulses[0], p0 + 1);
        check_frame(0, "a_post_rst");
        check("a_post_rst_rx_cnt", rxc[0], 1);
        check("a_post_rst_tx_cnt", txc[0], 1);
      end
      begin : scen_b
        int n;
        n = 0;
        while (pulses[1] < 1 && n < 3000) begin @(negedge clk); n++; end
        rec[1] = 1'b0;
        check("b_done", pulses[1], 1);
        check_frame(1, "b_odd");
        check("b_last_sel", words[1].size() == 31 ? words[1][30][17:16] : 2'bxx, 2'b10);
      end
      begin : scen_c
        int n;
        n = 0;
        while (pulses[2] < 1 && n < 3000) begin @(negedge clk); n++; end
        rec[2] = 1'b0;
        check("c_done", pulses[2], 1);
        check("c_stall_cycles", stall_hi[2], 0);
        check("c_stb_cycles", stb_cyc[2], 258);
        check("c_stb_runs", stb_runs[2], 1);
        check_frame(2, "c_nostall");
      end
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
